// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Holds the fetch FSM state encoding, memory command codes and datapath widths.
package cpu_pkg;

  localparam int PC_W    = 9;
  localparam int INSTR_W = 16;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_IF1    = 3'd1,
    S_IF2    = 3'd2,
    S_UPDATE = 3'd3,
    S_WAIT   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/load_enable_reg.sv
// Width-parameterized register with load enable and asynchronous active-low clear.
// Output follows d one cycle after load; holds otherwise; no backpressure.
module load_enable_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: two-cycle synchronous RAM read into ir, pc increment, then hold
// ir_valid until the control FSM acks; an ack may carry a pc redirect. Ack-to-valid is 4 cycles.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [PC_W-1:0]    mem_addr,
  output logic [1:0]         mem_cmd,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ack,
  input  logic               pc_load,
  input  logic [PC_W-1:0]    pc_target
);

  fetch_state_t state, state_next;

  logic            pc_ld;
  logic            ir_ld;
  logic [PC_W-1:0] pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_RESET;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:  if (start) state_next = S_IF1;
      S_IF1:    state_next = S_IF2;
      S_IF2:    state_next = S_UPDATE;
      S_UPDATE: state_next = S_WAIT;
      S_WAIT:   if (ir_ack) state_next = S_IF1;
      default:  state_next = S_RESET;
    endcase
  end

  // Outputs decode from the registered state only, so reset clears mem_cmd without a clock.
  always_comb begin
    mem_cmd  = MEM_NONE;
    ir_valid = 1'b0;
    ir_ld    = 1'b0;
    pc_ld    = 1'b0;
    pc_next  = pc + PC_W'(1);
    case (state)
      S_IF1: mem_cmd = MEM_READ;
      S_IF2: begin
        mem_cmd = MEM_READ;
        ir_ld   = 1'b1;
      end
      S_UPDATE: pc_ld = 1'b1;
      S_WAIT: begin
        ir_valid = 1'b1;
        if (ir_ack && pc_load) begin
          pc_ld   = 1'b1;
          pc_next = pc_target;
        end
      end
      default: ;
    endcase
  end

  load_enable_reg #(.W(PC_W)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_ld),
    .d     (pc_next),
    .q     (pc)
  );

  load_enable_reg #(.W(INSTR_W)) u_ir_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ir_ld),
    .d     (mem_rdata),
    .q     (ir)
  );

  assign mem_addr = pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state changes occur on the rising edge of clk except reset.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  level; permits leaving S_RESET and beginning the first fetch.
REQ-005 mem_rdata  input  16  read data from synchronous RAM, valid the cycle after the address is presented with a read command.
REQ-006 mem_addr  output  9  memory address; always equals pc.
REQ-007 mem_cmd  output  2  memory command: MEM_NONE=2'b00, MEM_READ=2'b01.
REQ-008 pc  output  9  program counter.
REQ-009 ir  output  16  instruction register, consumed by the control FSM and decoder.
REQ-010 ir_valid  output  1  high while ir holds an instruction not yet accepted.
REQ-011 ir_ack  input  1  control FSM accepts ir; sampled only in S_WAIT.
REQ-012 pc_load  input  1  redirect request; sampled only together with ir_ack in S_WAIT.
REQ-013 pc_target  input  9  redirect address, used when pc_load is taken.

Function
REQ-014 State machine states SHALL be S_RESET, S_IF1, S_IF2, S_UPDATE, S_WAIT, each as a registered state.
REQ-015 S_RESET: mem_cmd=MEM_NONE, ir_valid=0; next state is S_IF1 if start=1, otherwise S_RESET.
REQ-016 S_IF1: mem_cmd=MEM_READ; next state is S_IF2 unconditionally.
REQ-017 S_IF2: mem_cmd=MEM_READ; at the closing edge ir<=mem_rdata; next state is S_UPDATE.
REQ-018 S_UPDATE: mem_cmd=MEM_NONE; at the closing edge pc<=pc+1 modulo 512 (511 wraps to 0); next state is S_WAIT.
REQ-019 S_WAIT: ir_valid=1, mem_cmd=MEM_NONE, and ir and pc held stable.
REQ-020 In S_WAIT with ir_ack=0, the block SHALL stay in S_WAIT indefinitely.
REQ-021 In S_WAIT with ir_ack=1, the next state SHALL be S_IF1, and ir_valid SHALL drop in the following cycle.
REQ-022 In S_WAIT with ir_ack=1 and pc_load=1, pc<=pc_target at the same edge; the increment is not applied to that address until its own S_UPDATE.
REQ-023 ir_ack or pc_load asserted in any state other than S_WAIT SHALL be ignored.
REQ-024 pc_load=1 with ir_ack=0 SHALL be ignored.
REQ-025 start SHALL be ignored outside S_RESET.
REQ-026 Latency: start sampled high at edge E0 -> ir loaded at E2 -> pc incremented and ir_valid high after E3.
REQ-027 Ack-to-next-valid latency SHALL be 4 cycles.
REQ-028 ir SHALL change only at the closing edge of S_IF2; pc SHALL change only in S_UPDATE or on a taken redirect.

Reset
REQ-029 While rst_n=0: state=S_RESET, pc=9'h000, ir=16'h0000, ir_valid=0, mem_cmd=MEM_NONE, mem_addr=9'h000, independent of clk.
REQ-030 Reset asserted mid-fetch (S_IF1/S_IF2/S_UPDATE) SHALL abort the fetch with no ir or pc update, and mem_cmd SHALL return to MEM_NONE without waiting for a clock edge.
REQ-031 After rst_n deasserts, fetching SHALL resume only via start, from address 0.

Structure
REQ-032 Shared package cpu_pkg SHALL hold fetch_state_t, MEM_NONE/MEM_READ/MEM_WRITE, PC_W=9, and INSTR_W=16.
REQ-033 One sub-module, load_enable_reg (parameterized width, async active-low clear, load enable), SHALL be instantiated for pc and for ir.

Verification
REQ-034 Reset, mem[0]=16'hD105, start=1 for one cycle -> ir=16'hD105, ir_valid=1 four cycles after start is sampled, pc=9'h001.
REQ-035 ir_ack held low 10 cycles in S_WAIT -> ir, pc and ir_valid unchanged, mem_cmd=MEM_NONE throughout.
REQ-036 ir_ack=1 with pc_load=1 and pc_target=9'h0A0, mem[0xA0]=16'hA2B3 -> mem_addr=9'h0A0 during S_IF1/S_IF2, then ir=16'hA2B3 and pc=9'h0A1.
REQ-037 Redirect to 9'h1FF, mem[0x1FF]=16'h1234 -> ir=16'h1234, pc=9'h000 after S_UPDATE (wrap-around).
REQ-038 rst_n pulsed low during S_IF2 -> outputs at reset values immediately and no ir load; with start low, block stays in S_RESET with mem_cmd=MEM_NONE.
REQ-039 ir_ack and pc_load pulsed during S_IF1 -> no state, pc or ir effect; the fetch completes normally.
